// File: rtl/simon_autoplayer.sv
// simon_autoplayer: plays a Simon memory game on its own. Every game action is
// one pulse on pclk_o. Playback patterns are recorded into a 64-entry buffer
// and replayed in repeat mode. New guesses come from an 8-bit LFSR.
// Optional build macro SIMON_AUTOPLAYER_MISTAKE_EN adds the mistake_round
// input. In the round where rounds == mistake_round, the first repeat of that
// round is answered wrongly on purpose.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start, no game in progress
// RESET_OP   | pulse op with game_rst_o held high for the whole op
// DECIDE     | one cycle: sample game LEDs, choose the next op
// INPUT_OP   | pulse op presenting a generated guess
// PLAY_OP    | pulse op stepping the game's playback (pattern recorded)
// REPEAT_OP  | pulse op presenting a recorded pattern back to the game
// END        | game over, outputs frozen until the next start
module simon_autoplayer #(
    parameter int SETUP_CYC  = 2,
    parameter int HIGH_CYC   = 2,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_ROUNDS = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       level_i,
    input  logic [2:0] mode_leds,
    input  logic [3:0] pattern_leds,
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
    input  logic [6:0] mistake_round,
`endif
    output logic       pclk_o,
    output logic       game_rst_o,
    output logic       level_o,
    output logic [3:0] pattern_o,
    output logic       busy,
    output logic       done,
    output logic       won,
    output logic       err,
    output logic [6:0] rounds
);
    typedef enum logic [2:0] {
        S_IDLE, S_RESET_OP, S_DECIDE, S_INPUT_OP, S_PLAY_OP, S_REPEAT_OP, S_END
    } state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_SETTLE} phase_t;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HIGH_LD   = 8'(HIGH_CYC - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
    localparam logic [6:0] MAX_R     = 7'(MAX_ROUNDS);
    localparam logic [2:0] MODE_INPUT  = 3'b001;
    localparam logic [2:0] MODE_PLAY   = 3'b010;
    localparam logic [2:0] MODE_REPEAT = 3'b100;
    localparam logic [2:0] MODE_DONE   = 3'b111;

    state_t state, state_nxt, last_op;
    phase_t phase, phase_nxt;
    logic [7:0] tmr, tmr_nxt;
    logic [7:0] lfsr, lfsr_nxt;
    logic [6:0] play_idx, play_wr, rounds_inc;
    logic [5:0] rep_idx, rep_rd;
    logic [3:0] pat_mem [0:63];
    logic [3:0] gen_pat, rep_pat;
    logic in_op, first_play, first_rep;
    logic start_game, do_input, do_play, do_repeat, round_done, go_end, end_won, end_err;

    assign in_op = (state == S_RESET_OP) || (state == S_INPUT_OP) ||
                   (state == S_PLAY_OP) || (state == S_REPEAT_OP);
    assign pclk_o     = in_op && (phase == PH_HIGH);
    assign game_rst_o = (state == S_RESET_OP);

    assign lfsr_nxt   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign gen_pat    = level_o ? (4'b0001 << lfsr_nxt[1:0]) : lfsr_nxt[3:0];
    assign first_play = (last_op != S_PLAY_OP);
    assign first_rep  = (last_op != S_REPEAT_OP);
    assign play_wr    = first_play ? 7'd0 : play_idx;
    assign rep_rd     = first_rep ? 6'd0 : rep_idx;
    assign rounds_inc = rounds + 7'd1;
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
    assign rep_pat = (first_rep && (rounds == mistake_round)) ? (pat_mem[0] ^ 4'b0001)
                                                              : pat_mem[rep_rd];
`else
    assign rep_pat = pat_mem[rep_rd];
`endif

    // Next state: pulse-op phase timer and the decision on sampled game LEDs
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        tmr_nxt    = tmr;
        start_game = 1'b0;
        do_input   = 1'b0;
        do_play    = 1'b0;
        do_repeat  = 1'b0;
        round_done = 1'b0;
        go_end     = 1'b0;
        end_won    = 1'b0;
        end_err    = 1'b0;
        case (state)
            S_IDLE, S_END: begin
                if (start) begin
                    start_game = 1'b1;
                    state_nxt  = S_RESET_OP;
                    phase_nxt  = PH_SETUP;
                    tmr_nxt    = SETUP_LD;
                end
            end
            S_RESET_OP, S_INPUT_OP, S_PLAY_OP, S_REPEAT_OP: begin
                if (tmr != 8'd0) begin
                    tmr_nxt = tmr - 8'd1;
                end else begin
                    case (phase)
                        PH_SETUP: begin
                            phase_nxt = PH_HIGH;
                            tmr_nxt   = HIGH_LD;
                        end
                        PH_HIGH: begin
                            phase_nxt = PH_SETTLE;
                            tmr_nxt   = SETTLE_LD;
                        end
                        default: state_nxt = S_DECIDE;
                    endcase
                end
            end
            S_DECIDE: begin
                phase_nxt = PH_SETUP;
                tmr_nxt   = SETUP_LD;
                case (mode_leds)
                    MODE_INPUT: begin
                        round_done = (last_op == S_REPEAT_OP);
                        if (round_done && (rounds_inc == MAX_R)) begin
                            go_end    = 1'b1;
                            end_won   = 1'b1;
                            state_nxt = S_END;
                        end else begin
                            do_input  = 1'b1;
                            state_nxt = S_INPUT_OP;
                        end
                    end
                    MODE_PLAY: begin
                        // a full buffer with playback still running cannot be replayed
                        if (!first_play && (play_idx == 7'd64)) begin
                            go_end    = 1'b1;
                            end_err   = 1'b1;
                            state_nxt = S_END;
                        end else begin
                            do_play   = 1'b1;
                            state_nxt = S_PLAY_OP;
                        end
                    end
                    MODE_REPEAT: begin
                        do_repeat = 1'b1;
                        state_nxt = S_REPEAT_OP;
                    end
                    MODE_DONE: begin
                        go_end    = 1'b1;
                        state_nxt = S_END;
                    end
                    default: begin
                        go_end    = 1'b1;
                        end_err   = 1'b1;
                        state_nxt = S_END;
                    end
                endcase
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; last_op remembers which op led into DECIDE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            phase   <= PH_SETUP;
            tmr     <= 8'd0;
            last_op <= S_IDLE;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            tmr   <= tmr_nxt;
            if (in_op) last_op <= state;
        end
    end

    // Game datapath: outputs, round count, generator and buffer indices
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_o   <= 1'b0;
            pattern_o <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            won       <= 1'b0;
            err       <= 1'b0;
            rounds    <= 7'd0;
            lfsr      <= 8'h01;
            play_idx  <= 7'd0;
            rep_idx   <= 6'd0;
        end else begin
            if (start_game) begin
                level_o   <= level_i;
                pattern_o <= 4'd0;
                busy      <= 1'b1;
                done      <= 1'b0;
                won       <= 1'b0;
                err       <= 1'b0;
                rounds    <= 7'd0;
                play_idx  <= 7'd0;
                rep_idx   <= 6'd0;
            end
            if (round_done) rounds <= rounds_inc;
            if (do_input) begin
                lfsr      <= lfsr_nxt;
                pattern_o <= gen_pat;
            end
            if (do_play) play_idx <= play_wr + 7'd1;
            if (do_repeat) begin
                pattern_o <= rep_pat;
                rep_idx   <= rep_rd + 6'd1;
            end
            if (go_end) begin
                busy <= 1'b0;
                done <= 1'b1;
                won  <= end_won;
                err  <= end_err;
            end
        end
    end

    // Playback buffer; contents are meaningless until written in a round
    always_ff @(posedge clk) begin
        if (do_play) pat_mem[play_wr[5:0]] <= pattern_leds;
    end
endmodule
